freelist_checkpoint_stack: RTL and testbench

Branch-side producer of the free-list restore interface (free_list_restore, restore_flag) consumed by the R10K free list.
- On each dispatched branch, captures a snapshot of the dispatch-updated free list into one of NUM_CHECKPOINTS slots.
- Keeps every live snapshot current with retirements.
- On a mispredict, drives the resolving branch's snapshot with a restore pulse and squashes that slot plus all younger slots.

---
 rtl/freelist_checkpoint_stack_pkg.sv | 24 ++
 rtl/freelist_checkpoint_stack_slot_picker.sv | 20 ++
 rtl/freelist_checkpoint_stack.sv | 109 ++++++++++
 tb/tb_freelist_checkpoint_stack.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_checkpoint_stack_pkg.sv
// Shared sizing macros and types for the branch checkpoint stack.
// Optional build macro: FREELIST_CKPT_RETIRE_BYPASS_EN (see top module).
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef NUM_CHECKPOINTS
`define NUM_CHECKPOINTS 4
`endif

package freelist_checkpoint_stack_pkg;
    localparam int SS_WAYS        = `N;
    localparam int SCALAR_BITS    = `NUM_SCALAR_BITS;
    localparam int PHYS_REG_COUNT = `PHYS_REG_SZ_R10K;
    localparam int CKPT_COUNT     = `NUM_CHECKPOINTS;

    typedef logic [$clog2(PHYS_REG_COUNT)-1:0] PHYS_REG_IDX;
    typedef logic [$clog2(CKPT_COUNT)-1:0]     CHECKPOINT_IDX;
endpackage

// File: rtl/freelist_checkpoint_stack_slot_picker.sv
// Lowest-index-zero priority encoder used to pick a free checkpoint slot.
module freelist_checkpoint_stack_slot_picker #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         bits,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downward so the lowest clear bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!bits[i]) begin
                found = 1'b1;
                idx   = $clog2(WIDTH)'(i);
            end
        end
    end
endmodule

// File: rtl/freelist_checkpoint_stack.sv
// Per-branch free-list snapshots with retire tracking and mispredict restore.
// Define FREELIST_CKPT_RETIRE_BYPASS_EN to OR same-cycle retires into free_list_restore.
module freelist_checkpoint_stack
    import freelist_checkpoint_stack_pkg::*;
#(
    parameter int N               = SS_WAYS,
    parameter int NUM_CHECKPOINTS = CKPT_COUNT,
    parameter int PHYS_REGS       = PHYS_REG_COUNT
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   checkpoint_req,
    input  logic [PHYS_REGS-1:0]                   checkpoint_free_list,
    output logic                                   checkpoint_grant,
    output logic [$clog2(NUM_CHECKPOINTS)-1:0]     checkpoint_id,
    output logic                                   checkpoint_full,
    input  logic                                   resolve_valid,
    input  logic [$clog2(NUM_CHECKPOINTS)-1:0]     resolve_id,
    input  logic                                   resolve_mispredict,
    input  logic [N-1:0][$clog2(PHYS_REGS)-1:0]    phys_reg_retiring,
    input  logic [`NUM_SCALAR_BITS-1:0]            num_retiring_valid,
    output logic [PHYS_REGS-1:0]                   free_list_restore,
    output logic                                   restore_flag,
    output logic [$clog2(NUM_CHECKPOINTS+1)-1:0]   checkpoints_free
);
    localparam int NC     = NUM_CHECKPOINTS;
    localparam int FREE_W = $clog2(NC + 1);

    logic [NC-1:0]        valid_reg, valid_next;
    logic [PHYS_REGS-1:0] snapshot_reg [NC];
    logic [PHYS_REGS-1:0] snapshot_next [NC];
    logic [NC-1:0]        mask_reg [NC];
    logic [NC-1:0]        mask_next [NC];

    logic [N-1:0]         retire_en;
    logic [PHYS_REGS-1:0] retire_bits;
    logic [PHYS_REGS-1:0] restore_bits;
    logic [NC-1:0]        resolve_onehot, grant_onehot, kill;
    logic                 resolve_ok, slot_found;
    logic [FREE_W-1:0]    free_count;

    freelist_checkpoint_stack_slot_picker #(.WIDTH(NC)) u_picker (
        .bits  (valid_reg),
        .idx   (checkpoint_id),
        .found (slot_found)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_retire_en
        assign retire_en[gi] = (32'(num_retiring_valid) > gi);
    end

    always_comb begin
        retire_bits = '0;
        for (int i = 0; i < N; i++) begin
            if (retire_en[i]) retire_bits[phys_reg_retiring[i]] = 1'b1;
        end
    end

    assign restore_flag     = ~reset & resolve_valid & resolve_mispredict & valid_reg[resolve_id];
    assign resolve_ok       = ~reset & resolve_valid & ~resolve_mispredict & valid_reg[resolve_id];
    assign checkpoint_full  = &valid_reg;
    assign checkpoint_grant = ~reset & checkpoint_req & slot_found & ~restore_flag;
    assign resolve_onehot   = NC'(1) << resolve_id;
    assign grant_onehot     = checkpoint_grant ? (NC'(1) << checkpoint_id) : '0;

    // A mispredict squashes the resolving slot plus everything allocated after it.
    always_comb begin
        kill = '0;
        if (restore_flag)    kill = mask_reg[resolve_id] | resolve_onehot;
        else if (resolve_ok) kill = resolve_onehot;
    end

`ifdef FREELIST_CKPT_RETIRE_BYPASS_EN
    assign restore_bits = snapshot_reg[resolve_id] | retire_bits;
`else
    assign restore_bits = snapshot_reg[resolve_id];
`endif
    assign free_list_restore = restore_flag ? restore_bits : '0;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < NC; i++) free_count = free_count + FREE_W'(!valid_reg[i]);
    end
    assign checkpoints_free = free_count;

    for (genvar gi = 0; gi < NC; gi++) begin : g_slot
        assign valid_next[gi] = grant_onehot[gi] | (valid_reg[gi] & ~kill[gi]);
        assign snapshot_next[gi] = grant_onehot[gi] ? (checkpoint_free_list | retire_bits)
                                 : valid_reg[gi]    ? (snapshot_reg[gi] | retire_bits)
                                 :                    snapshot_reg[gi];
        // Every surviving live slot sees the new allocation as younger.
        assign mask_next[gi] = (grant_onehot[gi] | kill[gi]) ? '0
                             : ((mask_reg[gi] & ~kill) | (valid_reg[gi] ? grant_onehot : '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
            for (int i = 0; i < NC; i++) begin
                snapshot_reg[i] <= '0;
                mask_reg[i]     <= '0;
            end
        end else begin
            valid_reg    <= valid_next;
            snapshot_reg <= snapshot_next;
            mask_reg     <= mask_next;
        end
    end
endmodule

// File: tb/tb_freelist_checkpoint_stack.sv
// Directed and randomized checks of the checkpoint stack against an age-ordered slot model.
module tb_freelist_checkpoint_stack;
    import freelist_checkpoint_stack_pkg::*;

    localparam int NW = SS_WAYS;
    localparam int NC = CKPT_COUNT;
    localparam int PR = PHYS_REG_COUNT;
    localparam int IW = $clog2(NC);
    localparam int RW = $clog2(PR);
    localparam int CW = SCALAR_BITS;
    localparam int FW = $clog2(NC + 1);

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   checkpoint_req;
    logic [PR-1:0]          checkpoint_free_list;
    logic                   checkpoint_grant;
    logic [IW-1:0]          checkpoint_id;
    logic                   checkpoint_full;
    logic                   resolve_valid;
    logic [IW-1:0]          resolve_id;
    logic                   resolve_mispredict;
    logic [NW-1:0][RW-1:0]  phys_reg_retiring;
    logic [CW-1:0]          num_retiring_valid;
    logic [PR-1:0]          free_list_restore;
    logic                   restore_flag;
    logic [FW-1:0]          checkpoints_free;

    int total = 0;
    int bad   = 0;

    // Model: slot contents plus an allocation sequence number for age ordering.
    bit            m_valid [NC];
    logic [PR-1:0] m_snap  [NC];
    int            m_seq   [NC];
    int            seq_ctr = 0;

    freelist_checkpoint_stack dut (
        .clock                (clock),
        .reset                (reset),
        .checkpoint_req       (checkpoint_req),
        .checkpoint_free_list (checkpoint_free_list),
        .checkpoint_grant     (checkpoint_grant),
        .checkpoint_id        (checkpoint_id),
        .checkpoint_full      (checkpoint_full),
        .resolve_valid        (resolve_valid),
        .resolve_id           (resolve_id),
        .resolve_mispredict   (resolve_mispredict),
        .phys_reg_retiring    (phys_reg_retiring),
        .num_retiring_valid   (num_retiring_valid),
        .free_list_restore    (free_list_restore),
        .restore_flag         (restore_flag),
        .checkpoints_free     (checkpoints_free)
    );

    always #5 clock = ~clock;

    function automatic logic [PR-1:0] ret_bits();
        logic [PR-1:0] r = '0;
        for (int i = 0; i < NW; i++)
            if (i < int'(num_retiring_valid)) r[phys_reg_retiring[i]] = 1'b1;
        return r;
    endfunction

    function automatic int m_free();
        int c = 0;
        for (int j = 0; j < NC; j++) if (!m_valid[j]) c++;
        return c;
    endfunction

    function automatic int m_lowest();
        for (int j = 0; j < NC; j++) if (!m_valid[j]) return j;
        return -1;
    endfunction

    function automatic bit m_restore();
        return !reset && resolve_valid && resolve_mispredict && m_valid[resolve_id];
    endfunction

    function automatic bit m_grant();
        return !reset && checkpoint_req && (m_lowest() >= 0) && !m_restore();
    endfunction

    function automatic logic [PR-1:0] m_flr();
        if (!m_restore()) return '0;
`ifdef FREELIST_CKPT_RETIRE_BYPASS_EN
        return m_snap[resolve_id] | ret_bits();
`else
        return m_snap[resolve_id];
`endif
    endfunction

    task automatic idle();
        checkpoint_req       = 1'b0;
        checkpoint_free_list = '0;
        resolve_valid        = 1'b0;
        resolve_id           = '0;
        resolve_mispredict   = 1'b0;
        phys_reg_retiring    = '0;
        num_retiring_valid   = '0;
    endtask

    // Advances one clock edge, applying the same edge to the model.
    task automatic tick();
        logic [PR-1:0] r;
        bit rs, ok, g;
        int id, rid;
        bit kill [NC];
        r   = ret_bits();
        rs  = m_restore();
        ok  = !reset && resolve_valid && !resolve_mispredict && m_valid[resolve_id];
        g   = m_grant();
        id  = m_lowest();
        rid = int'(resolve_id);
        @(posedge clock);
        if (reset) begin
            for (int j = 0; j < NC; j++) begin
                m_valid[j] = 1'b0;
                m_snap[j]  = '0;
            end
        end else begin
            for (int j = 0; j < NC; j++) begin
                kill[j] = (rs && m_valid[j] && (j == rid || m_seq[j] > m_seq[rid])) || (ok && j == rid);
            end
            for (int j = 0; j < NC; j++) begin
                if (m_valid[j]) m_snap[j] = m_snap[j] | r;
                if (kill[j]) m_valid[j] = 1'b0;
            end
            if (g) begin
                m_valid[id] = 1'b1;
                m_snap[id]  = checkpoint_free_list | r;
                m_seq[id]   = seq_ctr;
                seq_ctr++;
            end
        end
        #1;
    endtask

    task automatic alloc(input logic [PR-1:0] fl);
        idle();
        checkpoint_req       = 1'b1;
        checkpoint_free_list = fl;
        tick();
        idle();
    endtask

    task automatic mispredict_tick(input int id);
        idle();
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        resolve_id         = IW'(id);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset              = 1'b1;
        checkpoint_req     = 1'b1;
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        tick();
        #1;
        total++; if (checkpoint_grant !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", checkpoint_grant); end
        total++; if (restore_flag !== 1'b0) begin bad++; $display("FAIL reset_restore: got %b want 0", restore_flag); end
        total++; if (free_list_restore !== '0) begin bad++; $display("FAIL reset_flr: got %h want 0", free_list_restore); end
        total++; if (checkpoint_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", checkpoint_full); end
        total++; if (checkpoints_free !== FW'(NC)) begin bad++; $display("FAIL reset_free: got %0d want %0d", checkpoints_free, NC); end
        tick();
        reset = 1'b0;
        idle();
        $display("test_reset done");
    endtask

    task automatic test_alloc_basic();
        logic [PR-1:0] v = 64'hFFFF_0000_0000_0000;
        idle();
        checkpoint_req       = 1'b1;
        checkpoint_free_list = v;
        #1;
        total++; if (checkpoint_grant !== 1'b1) begin bad++; $display("FAIL basic_grant: got %b want 1", checkpoint_grant); end
        total++; if (checkpoint_id !== IW'(0)) begin bad++; $display("FAIL basic_id: got %0d want 0", checkpoint_id); end
        total++; if (checkpoints_free !== FW'(4)) begin bad++; $display("FAIL basic_free_before: got %0d want 4", checkpoints_free); end
        tick();
        idle();
        #1;
        total++; if (checkpoints_free !== FW'(3)) begin bad++; $display("FAIL basic_free_after: got %0d want 3", checkpoints_free); end
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        resolve_id         = '0;
        #1;
        total++; if (restore_flag !== 1'b1) begin bad++; $display("FAIL basic_restore: got %b want 1", restore_flag); end
        total++; if (free_list_restore !== v) begin bad++; $display("FAIL basic_snapshot: got %h want %h", free_list_restore, v); end
        tick();
        idle();
        #1;
        total++; if (checkpoints_free !== FW'(4)) begin bad++; $display("FAIL basic_free_restored: got %0d want 4", checkpoints_free); end
        $display("test_alloc_basic done");
    endtask

    task automatic test_full();
        for (int k = 0; k < NC; k++) alloc({$urandom, $urandom});
        checkpoint_req = 1'b1;
        #1;
        total++; if (checkpoint_full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", checkpoint_full); end
        total++; if (checkpoint_grant !== 1'b0) begin bad++; $display("FAIL full_grant: got %b want 0", checkpoint_grant); end
        total++; if (checkpoints_free !== FW'(0)) begin bad++; $display("FAIL full_free: got %0d want 0", checkpoints_free); end
        resolve_valid      = 1'b1;
        resolve_id         = IW'(2);
        resolve_mispredict = 1'b0;
        #1;
        total++; if (checkpoint_grant !== 1'b0) begin bad++; $display("FAIL full_same_cycle_grant: got %b want 0", checkpoint_grant); end
        tick();
        idle();
        checkpoint_req = 1'b1;
        #1;
        total++; if (checkpoint_grant !== 1'b1) begin bad++; $display("FAIL full_regrant: got %b want 1", checkpoint_grant); end
        total++; if (checkpoint_id !== IW'(2)) begin bad++; $display("FAIL full_regrant_id: got %0d want 2", checkpoint_id); end
        tick();
        mispredict_tick(0);
        #1;
        total++; if (checkpoints_free !== FW'(4)) begin bad++; $display("FAIL full_cleanup_free: got %0d want 4", checkpoints_free); end
        $display("test_full done");
    endtask

    task automatic test_mispredict_middle();
        logic [PR-1:0] v [3];
        for (int k = 0; k < 3; k++) begin
            v[k] = {$urandom, $urandom};
            alloc(v[k]);
        end
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        resolve_id         = IW'(1);
        #1;
        total++; if (restore_flag !== 1'b1) begin bad++; $display("FAIL mid_restore: got %b want 1", restore_flag); end
        total++; if (free_list_restore !== v[1]) begin bad++; $display("FAIL mid_snapshot: got %h want %h", free_list_restore, v[1]); end
        tick();
        idle();
        #1;
        total++; if (checkpoints_free !== FW'(3)) begin bad++; $display("FAIL mid_free: got %0d want 3", checkpoints_free); end
        checkpoint_req = 1'b1;
        #1;
        total++; if (checkpoint_id !== IW'(1)) begin bad++; $display("FAIL mid_next_id: got %0d want 1", checkpoint_id); end
        idle();
        mispredict_tick(0);
        $display("test_mispredict_middle done");
    endtask

    task automatic test_retire();
        logic [PR-1:0] a   = 64'h0000_00F0_0000_0000;
        logic [PR-1:0] exp = 64'h0000_00F0_0000_0220;
        alloc(a);
        phys_reg_retiring[0] = RW'(5);
        phys_reg_retiring[1] = RW'(9);
        phys_reg_retiring[2] = RW'(30);
        num_retiring_valid   = CW'(2);
        tick();
        idle();
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        resolve_id         = '0;
        #1;
        total++; if (free_list_restore !== exp) begin bad++; $display("FAIL retire_snapshot: got %h want %h", free_list_restore, exp); end
        tick();
        idle();
        $display("test_retire done");
    endtask

    task automatic test_mispredict_with_req();
        for (int k = 0; k < 3; k++) alloc({$urandom, $urandom});
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        resolve_id         = '0;
        checkpoint_req     = 1'b1;
        #1;
        total++; if (checkpoint_grant !== 1'b0) begin bad++; $display("FAIL mreq_grant: got %b want 0", checkpoint_grant); end
        total++; if (restore_flag !== 1'b1) begin bad++; $display("FAIL mreq_restore: got %b want 1", restore_flag); end
        tick();
        idle();
        #1;
        total++; if (checkpoints_free !== FW'(4)) begin bad++; $display("FAIL mreq_free: got %0d want 4", checkpoints_free); end
        $display("test_mispredict_with_req done");
    endtask

    task automatic test_bypass();
        logic exp_bit;
`ifdef FREELIST_CKPT_RETIRE_BYPASS_EN
        exp_bit = 1'b1;
`else
        exp_bit = 1'b0;
`endif
        alloc('0);
        resolve_valid        = 1'b1;
        resolve_mispredict   = 1'b1;
        resolve_id           = '0;
        phys_reg_retiring[0] = RW'(12);
        num_retiring_valid   = CW'(1);
        #1;
        total++; if (free_list_restore[12] !== exp_bit) begin bad++; $display("FAIL bypass_bit12: got %b want %b", free_list_restore[12], exp_bit); end
        tick();
        idle();
        $display("test_bypass done");
    endtask

    task automatic test_random();
        int exp_id;
        logic [PR-1:0] exp_flr;
        for (int c = 0; c < 400; c++) begin
            checkpoint_req       = ($urandom_range(0, 1) == 1);
            checkpoint_free_list = {$urandom, $urandom};
            resolve_valid        = ($urandom_range(0, 2) != 0);
            resolve_id           = IW'($urandom_range(0, NC - 1));
            resolve_mispredict   = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NW; i++) phys_reg_retiring[i] = RW'($urandom_range(0, PR - 1));
            num_retiring_valid   = CW'($urandom_range(0, NW));
            #1;
            exp_id  = m_lowest();
            exp_flr = m_flr();
            total++; if (checkpoint_grant !== m_grant()) begin bad++; $display("FAIL rnd_grant c=%0d: got %b want %b", c, checkpoint_grant, m_grant()); end
            if (m_grant()) begin
                total++; if (checkpoint_id !== IW'(exp_id)) begin bad++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, checkpoint_id, exp_id); end
            end
            total++; if (checkpoint_full !== (m_free() == 0)) begin bad++; $display("FAIL rnd_full c=%0d: got %b want %b", c, checkpoint_full, m_free() == 0); end
            total++; if (checkpoints_free !== FW'(m_free())) begin bad++; $display("FAIL rnd_free c=%0d: got %0d want %0d", c, checkpoints_free, m_free()); end
            total++; if (restore_flag !== m_restore()) begin bad++; $display("FAIL rnd_restore c=%0d: got %b want %b", c, restore_flag, m_restore()); end
            total++; if (free_list_restore !== exp_flr) begin bad++; $display("FAIL rnd_flr c=%0d: got %h want %h", c, free_list_restore, exp_flr); end
            tick();
        end
        idle();
        $display("test_random done");
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        test_reset();
        test_alloc_basic();
        test_full();
        test_mispredict_middle();
        test_retire();
        test_mispredict_with_req();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
